spi_rx: RTL and testbench

- SPI slave receiver: the far end of the LCD/flash/SD SPI link driven by the peripheral's SPI master.
- Oversamples csn/sck/mosi with Bus2IP_Clk, deserialises MSB-first words and buffers them in a small internal FWFT FIFO for a consumer (bus read logic or bench scoreboard).
- Tags each word as first-in-frame, so command and data bytes can be told apart; flags overflow and truncated frames.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_rx_sync.sv | 70 +++++++
 rtl/spi_rx.sv | 178 +++++++++++++++++
 tb/tb_spi_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path.
package spi_pkg;

    // Mode 0 samples mosi on the rising sck edge
    localparam bit SPI_MODE0 = 1'b1;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_DEPTH_LOG2 = 2;
    localparam int unsigned SYNC_STAGES    = 2;

    typedef struct packed {
        logic                 first;
        logic [DEF_WIDTH-1:0] data;
    } spi_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Synchronisers and registered edge pulses for csn/sck/mosi.
// sck_fall port exists only when SPI_RX_MISO_EN is defined.
module spi_rx_sync
    import spi_pkg::*;
(
    input  logic Bus2IP_Clk,
    input  logic rst,
    input  logic csn,
    input  logic sck,
    input  logic mosi,
    output logic csn_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic csn_rise,
    output logic csn_fall
`ifdef SPI_RX_MISO_EN
    ,
    output logic sck_fall
`endif
);

    localparam int unsigned AGE_W = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES:0]   csn_q;
    logic [SYNC_STAGES:0]   sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [AGE_W-1:0]       age;
    logic                   hist_ok;

    // Edges are only trusted once every history stage holds a real post-reset
    // sample, so a csn already low when reset releases is not seen as a fall.
    assign hist_ok = (age == AGE_W'(SYNC_STAGES + 1));

    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            csn_q    <= '1;
            sck_q    <= '0;
            mosi_q   <= '0;
            age      <= '0;
            csn_s    <= 1'b1;
            mosi_s   <= 1'b0;
            sck_rise <= 1'b0;
            csn_rise <= 1'b0;
            csn_fall <= 1'b0;
        end else begin
            csn_q    <= {csn_q[SYNC_STAGES-1:0], csn};
            sck_q    <= {sck_q[SYNC_STAGES-1:0], sck};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
            if (!hist_ok) begin
                age <= age + AGE_W'(1);
            end
            csn_s    <= csn_q[SYNC_STAGES-1];
            mosi_s   <= mosi_q[SYNC_STAGES-1];
            sck_rise <= hist_ok &  sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
            csn_rise <= hist_ok &  csn_q[SYNC_STAGES-1] & ~csn_q[SYNC_STAGES];
            csn_fall <= hist_ok & ~csn_q[SYNC_STAGES-1] &  csn_q[SYNC_STAGES];
        end
    end

`ifdef SPI_RX_MISO_EN
    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            sck_fall <= 1'b0;
        end else begin
            sck_fall <= hist_ok & ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
        end
    end
`endif

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver with first-word tagging and a small FWFT FIFO.
// Define SPI_RX_MISO_EN to return the inverse of each received word on miso.
module spi_rx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic             Bus2IP_Clk,
    input  logic             rst,
    input  logic             csn,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] dout,
    output logic             dout_first,
    input  logic             rd,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic             first;
        logic [WIDTH-1:0] data;
    } rx_word_t;

    logic csn_s, mosi_s, sck_rise, csn_rise, csn_fall;
`ifdef SPI_RX_MISO_EN
    logic sck_fall;
`endif

    spi_rx_sync u_sync (
        .Bus2IP_Clk (Bus2IP_Clk),
        .rst        (rst),
        .csn        (csn),
        .sck        (sck),
        .mosi       (mosi),
        .csn_s      (csn_s),
        .mosi_s     (mosi_s),
        .sck_rise   (sck_rise),
        .csn_rise   (csn_rise),
        .csn_fall   (csn_fall)
`ifdef SPI_RX_MISO_EN
        ,
        .sck_fall   (sck_fall)
`endif
    );

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             first_flag, first_nxt;
    logic [WIDTH-2:0] sr, sr_nxt;
    logic             push_c;
    logic             frame_err_nxt;
    rx_word_t         wr_word;

    rx_word_t         mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    rx_word_t         head;
    logic             do_pop, do_push, drop;

    // Completed word: the stored bits plus the bit arriving this cycle
    assign wr_word = '{first: first_flag, data: {sr, mosi_s}};

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        first_nxt     = first_flag;
        sr_nxt        = sr;
        push_c        = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    first_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (csn_rise) begin
                    state_nxt     = IDLE;
                    frame_err_nxt = (cnt != '0);
                    cnt_nxt       = '0;
                end else if (sck_rise && !csn_s) begin
                    sr_nxt = (WIDTH-1)'({sr, mosi_s});
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        push_c    = 1'b1;
                        cnt_nxt   = '0;
                        first_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_pop  = rd && !empty;
    assign do_push = push_c && (!full || do_pop);
    assign drop    = push_c && full && !do_pop;

    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            first_flag <= 1'b0;
            sr         <= '0;
            wptr       <= '0;
            rptr       <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            first_flag <= first_nxt;
            sr         <= sr_nxt;
            frame_err  <= frame_err_nxt;
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (do_push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= wr_word;
        end
    end

    assign head       = mem[rptr[DEPTH_LOG2-1:0]];
    assign dout       = empty ? '0 : head.data;
    assign dout_first = !empty && head.first;

`ifdef SPI_RX_MISO_EN
    logic [WIDTH-1:0] tx_sr;

    // The fall that closes a word is skipped so the master's next rising
    // edge samples the MSB of the freshly loaded word.
    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            tx_sr <= '0;
        end else if (state == SHIFT && csn_rise) begin
            tx_sr <= '0;
        end else if (push_c) begin
            tx_sr <= ~wr_word.data;
        end else if (state == SHIFT && sck_fall && cnt != '0) begin
            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign miso = tx_sr[WIDTH-1];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Randomised scoreboard bench for spi_rx: stimulus queues expected words, a
// monitor pops the DUT FIFO and compares.
module tb_spi_rx;
    import spi_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int          HALF  = 4;

    logic         Bus2IP_Clk = 1'b0;
    logic         rst  = 1'b1;
    logic         csn  = 1'b1;
    logic         sck  = 1'b0;
    logic         mosi = 1'b0;
    logic         rd   = 1'b0;
    logic         clr  = 1'b0;
    logic         miso, dout_first, empty, full, overflow, frame_err;
    logic [W-1:0] dout;

    typedef struct {
        logic         first;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q [$];
    exp_t         mon_e;
    int           total = 0;
    int           bad   = 0;
    logic         cur_first = 1'b0;
    logic         exp_ovf   = 1'b0;
    bit           drain_en  = 1'b0;
    bit           pop_req   = 1'b0;
    int           fe_seen   = 0;
    int           fe_exp    = 0;
    logic         miso_hi   = 1'b0;
    logic [W-1:0] miso_cap  = '0;

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    spi_rx dut (
        .Bus2IP_Clk (Bus2IP_Clk),
        .rst        (rst),
        .csn        (csn),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .dout       (dout),
        .dout_first (dout_first),
        .rd         (rd),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr        (clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a completed word is stored unless DEPTH words are
    // already waiting and no pop coincides with it.
    task automatic model_word(input logic [W-1:0] w, input bit coinc);
        if (exp_q.size() >= DEPTH && !coinc) begin
            exp_ovf = 1'b1;
        end else begin
            exp_q.push_back('{first: cur_first, data: w});
        end
        cur_first = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits,
                             input bit coinc, input bit chk_lat);
        for (int i = W - 1; i >= int'(W) - nbits; i--) begin
            bit last;
            last = (i == int'(W) - nbits);
            mosi = w[i];
            repeat (HALF) @(negedge Bus2IP_Clk);
            miso_cap = {miso_cap[W-2:0], miso};
            sck = 1'b1;
            if (last && nbits == int'(W)) model_word(w, coinc);
            for (int k = 1; k <= HALF; k++) begin
                @(negedge Bus2IP_Clk);
                if (last && coinc && k == 2) pop_req = 1'b1;
                if (last && chk_lat && k == 3) check("lat_empty_3cyc", 32'(empty), 32'd1);
                if (last && chk_lat && k == 4) check("lat_empty_4cyc", 32'(empty), 32'd0);
            end
            sck = 1'b0;
        end
    endtask

    task automatic frame_start();
        csn = 1'b0;
        cur_first = 1'b1;
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge Bus2IP_Clk);
        csn = 1'b1;
        repeat (2 * HALF) @(negedge Bus2IP_Clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !empty) && n < 2000) begin
            @(negedge Bus2IP_Clk);
            n++;
        end
        check("drain_timeout", 32'(n < 2000), 32'd1);
        repeat (4) @(negedge Bus2IP_Clk);
    endtask

    // Monitor: pops whenever the DUT offers a word and the consumer is willing
    initial begin : monitor
        forever begin
            @(posedge Bus2IP_Clk);
            #2;
            rd = 1'b0;
            if (!rst && !empty && (pop_req || (drain_en && $urandom_range(3) != 0))) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 32'(dout), 32'(mon_e.data));
                    check("word_first", 32'(dout_first), 32'(mon_e.first));
                end
                rd = 1'b1;
                pop_req = 1'b0;
            end
        end
    end

    always @(negedge Bus2IP_Clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (miso !== 1'b0) miso_hi = 1'b1;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [W-1:0] exp_miso;
        repeat (3) @(negedge Bus2IP_Clk);
        rst = 1'b0;
        @(negedge Bus2IP_Clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_first", 32'(dout_first), 32'd0);

        // Two-word frame with push latency check
        drain_en = 1'b1;
        frame_start();
        send_bits(8'hA5, W, 1'b0, 1'b1);
        send_bits(8'h3C, W, 1'b0, 1'b0);
        frame_end();
        wait_drain();

        // Overflow: five words into a four-deep FIFO with no reads
        drain_en = 1'b0;
        frame_start();
        for (int k = 1; k <= 5; k++) begin
            send_bits(W'(k), W, 1'b0, 1'b0);
            if (k == 4) check("full_after_4", 32'(full), 32'(exp_q.size() == DEPTH));
        end
        check("overflow_set", 32'(overflow), 32'(exp_ovf));
        check("full_after_5", 32'(full), 32'd1);
        frame_end();
        drain_en = 1'b1;
        wait_drain();
        check("overflow_sticky", 32'(overflow), 32'(exp_ovf));
        clr = 1'b1;
        @(negedge Bus2IP_Clk);
        clr = 1'b0;
        exp_ovf = 1'b0;
        @(negedge Bus2IP_Clk);
        check("overflow_clr", 32'(overflow), 32'(exp_ovf));

        // Truncated frame then a clean one
        frame_start();
        send_bits(8'hF8, 5, 1'b0, 1'b0);
        fe_exp++;
        frame_end();
        check("frame_err_pulse", 32'(fe_seen), 32'(fe_exp));
        check("trunc_empty", 32'(empty), 32'd1);
        frame_start();
        send_bits(8'h7E, W, 1'b0, 1'b0);
        frame_end();
        wait_drain();

        // Word completes on a full FIFO in the same cycle as a pop
        drain_en = 1'b0;
        frame_start();
        send_bits(8'h11, W, 1'b0, 1'b0);
        send_bits(8'h22, W, 1'b0, 1'b0);
        send_bits(8'h33, W, 1'b0, 1'b0);
        send_bits(8'h44, W, 1'b0, 1'b0);
        check("full_before_coinc", 32'(full), 32'd1);
        send_bits(8'h55, W, 1'b1, 1'b0);
        check("full_after_coinc", 32'(full), 32'(exp_q.size() == DEPTH));
        check("ovf_after_coinc", 32'(overflow), 32'(exp_ovf));
        frame_end();
        drain_en = 1'b1;
        wait_drain();

        // Reset in the middle of a frame; the rest of that frame is ignored
        frame_start();
        send_bits(8'hE0, 3, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge Bus2IP_Clk);
        rst = 1'b0;
        send_bits(8'hA0, 3, 1'b0, 1'b0);
        frame_end();
        check("post_rst_empty", 32'(empty), 32'd1);
        frame_start();
        send_bits(8'h55, W, 1'b0, 1'b0);
        frame_end();
        wait_drain();
        check("post_rst_overflow", 32'(overflow), 32'd0);
        check("post_rst_frame_err", 32'(fe_seen), 32'(fe_exp));

        // Loopback word pair: miso during the second word
        frame_start();
        send_bits(8'h0F, W, 1'b0, 1'b0);
        send_bits(8'h00, W, 1'b0, 1'b0);
        frame_end();
`ifdef SPI_RX_MISO_EN
        exp_miso = ~8'h0F;
`else
        exp_miso = 8'h00;
`endif
        check("miso_second_word", 32'(miso_cap), 32'(exp_miso));
        wait_drain();

        // Random frames, some ending mid-word
        for (int f = 0; f < 10; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            frame_start();
            for (int k = 0; k < nw; k++) send_bits(W'($urandom), W, 1'b0, 1'b0);
            if ($urandom_range(3) == 0) begin
                send_bits(W'($urandom), $urandom_range(1, W - 1), 1'b0, 1'b0);
                fe_exp++;
            end
            frame_end();
        end
        wait_drain();
        check("final_frame_err", 32'(fe_seen), 32'(fe_exp));
        check("final_overflow", 32'(overflow), 32'(exp_ovf));
        check("final_full", 32'(full), 32'd0);
`ifndef SPI_RX_MISO_EN
        check("miso_always_zero", 32'(miso_hi), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
